// File: rtl/npc_multicycle_ctrl_pkg.sv
// Shared constants for the NPC multi-cycle sequencer: FSM state encodings, halt codes and reset PC.
package npc_multicycle_ctrl_pkg;

    // HALT has no encoding of its own: the sticky halted flag freezes the FSM wherever it stopped.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_FWAIT  = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_MEM    = 3'd5,
        S_MWAIT  = 3'd6,
        S_WB     = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        HALT_NONE    = 2'b00,
        HALT_EBREAK  = 2'b01,
        HALT_ILLEGAL = 2'b10,
        HALT_TIMEOUT = 2'b11
    } halt_code_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/npc_wait_timer.sv
// Memory-transaction watchdog: cleared outside a transaction, counts while waiting, flags the last allowed cycle.
module npc_wait_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expire
);

    localparam int W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [W-1:0] LAST = W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    // Fires during the TIMEOUT_CYCLES-th waiting cycle so the FSM halts on that edge.
    assign expire = (TIMEOUT_CYCLES > 0) && en && (count == LAST);

endmodule

// File: rtl/npc_multicycle_ctrl.sv
// NPC multi-cycle sequencer: owns the PC, steps IFU->IDU->EXU->LSU->WB, counts cycles/retires, halts on faults.
module npc_multicycle_ctrl
    import npc_multicycle_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = RESET_PC_DEFAULT,
    parameter int          CNT_W          = 64,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    input  logic             imem_resp_valid,
    output logic             ir_we,
    input  logic             dec_is_load,
    input  logic             dec_is_store,
    input  logic             dec_ebreak,
    input  logic             dec_illegal,
    output logic             dmem_req_valid,
    output logic             dmem_req_we,
    input  logic             dmem_req_ready,
    input  logic             dmem_resp_valid,
    input  logic [31:0]      pc_next,
    output logic [31:0]      pc,
    output logic             pc_we,
    output logic             rf_we_en,
    output logic             halted,
    output logic [1:0]       halt_code,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret
);

    state_t state;
    logic   store_q;
    logic   in_wait;
    logic   expire;

    assign in_wait = !halted && (state == S_FETCH || state == S_FWAIT ||
                                 state == S_MEM   || state == S_MWAIT);

    npc_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (!in_wait),
        .en    (in_wait),
        .expire(expire)
    );

    // The instruction is only on the bus during the response cycle, so the IR latch strobe cannot be registered.
    assign ir_we = !halted && (state == S_FWAIT) && imem_resp_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            pc             <= RESET_PC;
            cycle_cnt      <= '0;
            instret        <= '0;
            halted         <= 1'b0;
            halt_code      <= HALT_NONE;
            imem_req_valid <= 1'b0;
            dmem_req_valid <= 1'b0;
            dmem_req_we    <= 1'b0;
            pc_we          <= 1'b0;
            rf_we_en       <= 1'b0;
            store_q        <= 1'b0;
        end else if (!halted) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            pc_we     <= 1'b0;
            rf_we_en  <= 1'b0;
            case (state)
                S_IDLE: begin
                    state          <= S_FETCH;
                    imem_req_valid <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_req_ready) begin
                        imem_req_valid <= 1'b0;
                        state          <= S_FWAIT;
                    end else if (expire) begin
                        imem_req_valid <= 1'b0;
                        halted         <= 1'b1;
                        halt_code      <= HALT_TIMEOUT;
                    end
                end
                S_FWAIT: begin
                    if (imem_resp_valid) begin
                        state <= S_DECODE;
                    end else if (expire) begin
                        halted    <= 1'b1;
                        halt_code <= HALT_TIMEOUT;
                    end
                end
                S_DECODE: begin
                    if (dec_illegal) begin
                        halted    <= 1'b1;
                        halt_code <= HALT_ILLEGAL;
                    end else if (dec_ebreak) begin
                        halted    <= 1'b1;
                        halt_code <= HALT_EBREAK;
                        instret   <= instret + CNT_W'(1);
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    store_q <= dec_is_store;
                    if (dec_is_load || dec_is_store) begin
                        state          <= S_MEM;
                        dmem_req_valid <= 1'b1;
                        dmem_req_we    <= dec_is_store;
                    end else begin
                        state    <= S_WB;
                        pc_we    <= 1'b1;
                        rf_we_en <= 1'b1;
                    end
                end
                S_MEM: begin
                    if (dmem_req_ready) begin
                        dmem_req_valid <= 1'b0;
                        dmem_req_we    <= 1'b0;
                        state          <= S_MWAIT;
                    end else if (expire) begin
                        dmem_req_valid <= 1'b0;
                        dmem_req_we    <= 1'b0;
                        halted         <= 1'b1;
                        halt_code      <= HALT_TIMEOUT;
                    end
                end
                S_MWAIT: begin
                    if (dmem_resp_valid) begin
                        state    <= S_WB;
                        pc_we    <= 1'b1;
                        rf_we_en <= !store_q;
                    end else if (expire) begin
                        halted    <= 1'b1;
                        halt_code <= HALT_TIMEOUT;
                    end
                end
                S_WB: begin
                    pc             <= pc_next;
                    instret        <= instret + CNT_W'(1);
                    state          <= S_FETCH;
                    imem_req_valid <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
